// File: rtl/frec_divisor_pkg.sv
// Shared constants and types for the programmable clock divider family.
package frec_divisor_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_t;

  // Terminal counts for a 100 MHz system clock; 1 Hz needs CNT_W >= 26.
  localparam int unsigned DIV_1K_100M  = 49999;
  localparam int unsigned DIV_1HZ_100M = 49_999_999;

endpackage

// File: rtl/frec_divisor_ch.sv
// One divider channel: terminal-count counter, config registers, registered outputs.
module frec_divisor_ch
  import frec_divisor_pkg::*;
#(
  parameter int unsigned      CNT_W       = 16,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(DIV_1K_100M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             ld_this,
  input  logic [CNT_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  mode_t            mode_reg;
  logic             out_reg;
  logic             tick_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      div_reg  <= DIV_DEFAULT;
      mode_reg <= MODE_TOGGLE;
      out_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else if (sync || ld_this) begin
      // Sync outranks the load for phase, but a coincident load still takes its config.
      cnt      <= '0;
      out_reg  <= 1'b0;
      tick_reg <= 1'b0;
      if (ld_this) begin
        div_reg  <= ld_div;
        mode_reg <= mode_t'(ld_mode);
      end
    end else if (en) begin
      if (cnt == div_reg) begin
        cnt      <= '0;
        tick_reg <= 1'b1;
        out_reg  <= (mode_reg == MODE_PULSE) ? 1'b1 : ~out_reg;
      end else begin
        cnt      <= cnt + 1'b1;
        tick_reg <= 1'b0;
        if (mode_reg == MODE_PULSE) out_reg <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
      if (mode_reg == MODE_PULSE) out_reg <= 1'b0;
    end
  end

  assign clk_out = out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/frec_divisor_prog.sv
// Multi-channel programmable clock divider / tick generator sharing enable and sync.
module frec_divisor_prog
  import frec_divisor_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_DEFAULT = DIV_1K_100M,
  parameter int unsigned SEL_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [SEL_W-1:0] ld_sel,
  input  logic [CNT_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  // Out-of-range ld_sel matches no channel, so such loads are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ld_this;
    assign ld_this = ld && (ld_sel == SEL_W'(i));

    frec_divisor_ch #(
      .CNT_W      (CNT_W),
      .DIV_DEFAULT(CNT_W'(DIV_DEFAULT))
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sync   (sync),
      .ld_this(ld_this),
      .ld_div (ld_div),
      .ld_mode(ld_mode),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_frec_divisor_prog.sv
// Scoreboard bench for frec_divisor_prog: closed-form expectations queued per cycle, checked by a monitor.
module tb_frec_divisor_prog;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned N_CH  = 2;
  localparam int unsigned SEL_W = 3;

  logic             clk = 1'b0;
  logic             reset, en, sync, ld, ld_mode;
  logic [SEL_W-1:0] ld_sel;
  logic [CNT_W-1:0] ld_div;
  logic [N_CH-1:0]  clk_out, tick;

  always #5 clk = ~clk;

  frec_divisor_prog #(
    .CNT_W      (CNT_W),
    .N_CH       (N_CH),
    .DIV_DEFAULT(49999),
    .SEL_W      (SEL_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .ld     (ld),
    .ld_sel (ld_sel),
    .ld_div (ld_div),
    .ld_mode(ld_mode),
    .clk_out(clk_out),
    .tick   (tick)
  );

  typedef struct {
    int unsigned     cyc;
    string           name;
    logic [N_CH-1:0] co;
    logic [N_CH-1:0] tk;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_n = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Expected-value bookkeeping: enabled cycles since last realign, divisor, mode.
  int unsigned k_ch[N_CH];
  int unsigned d_ch[N_CH];
  logic        m_ch[N_CH];

  always @(posedge clk) begin
    exp_t e;
    cyc_n++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      e = sb.pop_front();
      if (e.cyc != cyc_n) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: entry for cycle %0d checked at cycle %0d", e.name, e.cyc, cyc_n);
      end else begin
        n_cmp += 2;
        if (clk_out !== e.co) begin
          n_bad++;
          $display("FAIL %s clk_out @%0d: got %b want %b", e.name, cyc_n, clk_out, e.co);
        end
        if (tick !== e.tk) begin
          n_bad++;
          $display("FAIL %s tick @%0d: got %b want %b", e.name, cyc_n, tick, e.tk);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic e, input logic s, input logic l,
                     input logic [SEL_W-1:0] sel, input int unsigned dv, input logic md,
                     input bit chk, input string nm);
    logic [N_CH-1:0] co, tk;
    bit hit, run;
    reset = r; en = e; sync = s; ld = l; ld_sel = sel; ld_div = CNT_W'(dv); ld_mode = md;
    for (int i = 0; i < N_CH; i++) begin
      hit = l && (sel == SEL_W'(i));
      run = 1'b0;
      if (r) begin
        k_ch[i] = 0; d_ch[i] = 49999; m_ch[i] = 1'b0;
      end else begin
        if (hit) begin d_ch[i] = dv; m_ch[i] = md; end
        if (s || hit) k_ch[i] = 0;
        else if (e) begin k_ch[i]++; run = 1'b1; end
      end
      tk[i] = run && ((k_ch[i] % (d_ch[i] + 1)) == 0);
      if (m_ch[i]) co[i] = tk[i];
      else         co[i] = ((k_ch[i] / (d_ch[i] + 1)) % 2) == 1;
    end
    if (chk) sb.push_back('{cyc_n + 1, nm, co, tk});
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic e, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, e, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, nm);
  endtask

  task automatic load(input int unsigned sel, input int unsigned dv, input logic md, input string nm);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, SEL_W'(sel), dv, md, 1'b1, nm);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync = 1'b0; ld = 1'b0; ld_sel = '0; ld_div = '0; ld_mode = 1'b0;
    for (int i = 0; i < N_CH; i++) begin k_ch[i] = 0; d_ch[i] = 49999; m_ch[i] = 1'b0; end
    @(negedge clk);

    // Reset defaults, then the first default tick 50000 enabled cycles later.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, "reset");
    for (int k = 1; k <= 50001; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0, (k <= 2 || k >= 49998), "dflt_first_tick");

    load(0, 3, 1'b0, "t2_ld");
    run(16, 1'b1, "t2_toggle3");

    load(1, 4, 1'b1, "t3_ld");
    run(10, 1'b1, "t3_pulse4");
    run(3, 1'b0, "t3_en_off");
    run(6, 1'b1, "t3_resume");

    load(0, 9, 1'b0, "t4_ld9");
    run(2, 1'b1, "t4_cnt2");
    load(0, 2, 1'b0, "t4_midld");
    run(4, 1'b1, "t4_after");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 7, 1'b1, 1'b1, "t4_sel5");
    run(4, 1'b1, "t4_post_sel5");

    load(0, 5, 1'b0, "t5_ld0");
    run(2, 1'b1, "t5_phase0");
    load(1, 5, 1'b0, "t5_ld1");
    run(3, 1'b1, "t5_phase1");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1, "t5_sync");
    run(14, 1'b1, "t5_aligned");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1, 1'b1, 1'b1, "t5_sync_ld");
    run(6, 1'b1, "t5_after_sync_ld");

    load(0, 0, 1'b0, "t6_ld_t0");
    run(6, 1'b1, "t6_toggle0");
    run(2, 1'b0, "t6_hold");
    load(1, 0, 1'b1, "t6_ld_p0");
    run(6, 1'b1, "t6_pulse0");
    load(0, 65535, 1'b0, "t6_ld_max");
    run(3, 1'b1, "t6_max");

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3, 1'b1, 1'b1, "t7_rst_ld");
    run(6, 1'b1, "t7_default");

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
